serial_subtractor16: RTL and testbench
======================================

Name: serial_subtractor16

Overview:
Bit-serial 16-bit two's-complement subtractor computing diff = a - b - bin, one bit per clock, LSB first. It is the sequential, inverse-operation counterpart to the team's combinational 16-bit ripple-carry adder. It trades latency for area: one 1-bit full-subtractor cell plus shift registers replace a 16-cell ripple chain. It sits beside the adder in the arithmetic datapath and uses a start/busy/done handshake.

Parameters:
WIDTH, 16, operand and result width in bits (minimum 2).
CNT_W, 5, bit-counter width; must satisfy 2**CNT_W > WIDTH.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  synchronous reset, active-high (one clock; reset is synchronous and active-high).
start  input  1  request; sampled only when accepted (see Behaviour).
a  input  WIDTH  minuend, sampled on the accept edge only.
b  input  WIDTH  subtrahend, sampled on the accept edge only.
bin  input  1  borrow-in, sampled on the accept edge only.
diff  output  WIDTH  result; held stable until the next accept.
bout  output  1  borrow-out (1 when the unsigned result is a < b + bin).
ovf  output  1  signed overflow flag.
busy  output  1  high while in RUN.
done  output  1  one-cycle pulse when results become valid.

Behaviour:
- Reset, checked on each clk edge: state=IDLE; diff=0, bout=0, ovf=0, busy=0, done=0; bit counter=0; internal shift registers=0.
- Reset wins over every other event. Reset in the middle of RUN aborts the operation: no done pulse, partial result discarded.
- States:
  - IDLE: waits for a request.
  - RUN: processes WIDTH bits.
  - DONE: one cycle, done=1.
- Accept: start=1 on an edge while in IDLE or DONE.
  - a, b and bin are loaded into shift registers.
  - The borrow register is set to bin and the counter is cleared.
  - Next state is RUN.
  - start while in RUN is ignored, with no effect on the operation or on outputs.
- RUN, each edge, counter k = 0..WIDTH-1:
  - d = a_k ^ b_k ^ br.
  - br_next = (~a_k & b_k) | (~a_k & br) | (b_k & br).
  - d is shifted into the result register from the MSB end; the operand registers shift right.
  - The counter increments.
  - On the edge with k = WIDTH-1:
    - diff is updated with the full result and bout = br_next.
    - ovf = (a[MSB] != b[MSB]) & (diff[MSB] != a[MSB]), using the latched MSBs.
    - Next state is DONE.
- Latency: if the accept occurs at edge E0, done is high for exactly the cycle following edge E0+WIDTH (16 clocks for WIDTH=16).
- busy is high from the cycle after E0 through the cycle ending at E0+WIDTH; busy and done are never high together.
- DONE:
  - Next edge goes to IDLE, or accepts a new operation if start=1 (back-to-back, no idle gap).
- Output stability:
  - diff, bout and ovf change only on the final RUN edge or on reset.
  - They are never partially updated mid-run; the internal result register is separate from diff.
- Arithmetic: modulo 2**WIDTH. Result equals {bout, diff} = {1'b0, a} - {1'b0, b} - bin, taking bout as the inverted carry.
- Boundaries:
  - a == b with bin=0 gives 0, bout=0.
  - 0 - 0 - 1 gives all-ones, bout=1.
  - The counter never exceeds WIDTH-1.

Decomposition:
- Shared package/header holds:
  - state encoding constants IDLE=2'd0, RUN=2'd1, DONE=2'd2 (2'd3 is illegal and recovers to IDLE);
  - the default WIDTH.
- One natural sub-module, full_subtractor, with ports (a, b, bin, d, bout), built gate-level to match the existing adder cell.
- The top level holds the FSM, counter, operand and result shift registers, and the borrow flop.

Test Plan:
1. a=0x0005, b=0x0003, bin=0, single-cycle start -> after 16 clocks done=1 for 1 cycle, diff=0x0002, bout=0, ovf=0; busy high for exactly 16 cycles before done.
2. a=0x0003, b=0x0005, bin=0 -> diff=0xFFFE, bout=1, ovf=0. Then a=0x0000, b=0x0000, bin=1 -> diff=0xFFFF, bout=1, ovf=0.
3. a=0x8000, b=0x0001 -> diff=0x7FFF, bout=0, ovf=1. Then a=0x7FFF, b=0xFFFF -> diff=0x8000, bout=1, ovf=1.
4. Start a=0x1234, b=0x0234. Pulse start with a=0xFFFF on RUN cycle 5 -> ignored; result diff=0x1000. Hold start high during the DONE cycle with a=0x0010, b=0x0001 -> accepted immediately; next done gives diff=0x000F, and the previous diff holds until then.
5. Start a=0xAAAA, b=0x5555; assert rst at RUN cycle 8 for 1 clock -> next cycle busy=0, done=0, diff=0, state IDLE; no done pulse follows. A fresh start then completes normally with diff=0x5555.
6. Random sweep of 1000 operand/bin triples, checked against the reference model {bout, diff} = a - b - bin and the ovf formula; diff must stay stable between done pulses.

Source files
------------

// File: rtl/serial_subtractor16_pkg.sv
// Shared definitions for the bit-serial subtractor: default width and FSM encoding.
package serial_subtractor16_pkg;

  localparam int WIDTH_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_subtractor16_full_subtractor.sv
// One-bit full-subtractor cell, gate-level to mirror the ripple adder's full-adder cell.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  logic a_n;
  logic t_ab;
  logic t_abin;
  logic t_bbin;

  xor g_d    (d, a, b, bin);
  not g_an   (a_n, a);
  and g_ab   (t_ab, a_n, b);
  and g_abin (t_abin, a_n, bin);
  and g_bbin (t_bbin, b, bin);
  or  g_bout (bout, t_ab, t_abin, t_bbin);

endmodule

// File: rtl/serial_subtractor16.sv
// Bit-serial a - b - bin, LSB first, one bit per clock with a start/busy/done handshake.
module serial_subtractor16
  import serial_subtractor16_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf,
  output logic             busy,
  output logic             done
);

  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   a_sr;
  logic [WIDTH-1:0]   b_sr;
  logic [WIDTH-1:0]   res_sr;
  logic               br;
  logic               a_msb;
  logic               b_msb;
  logic               d_bit;
  logic               br_nxt;
  logic               accept;
  logic               last;

  full_subtractor u_fs (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .bin  (br),
    .d    (d_bit),
    .bout (br_nxt)
  );

  assign accept = start && ((state == IDLE) || (state == DONE));
  assign last   = (state == RUN) && (cnt == CNT_W'(WIDTH - 1));
  assign busy   = (state == RUN);
  assign done   = (state == DONE);

  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE:    state_nxt = start ? RUN : IDLE;
      RUN:     state_nxt = last ? DONE : RUN;
      DONE:    state_nxt = start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      br     <= 1'b0;
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
      diff   <= '0;
      bout   <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        a_sr  <= a;
        b_sr  <= b;
        br    <= bin;
        cnt   <= '0;
        a_msb <= a[WIDTH-1];
        b_msb <= b[WIDTH-1];
      end else if (state == RUN) begin
        a_sr   <= a_sr >> 1;
        b_sr   <= b_sr >> 1;
        res_sr <= {d_bit, res_sr[WIDTH-1:1]};
        br     <= br_nxt;
        // Counter wraps to zero on the final bit so it never passes WIDTH-1.
        cnt    <= last ? '0 : cnt + 1'b1;
        if (last) begin
          diff <= {d_bit, res_sr[WIDTH-1:1]};
          bout <= br_nxt;
          ovf  <= (a_msb != b_msb) && (d_bit != a_msb);
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor16.sv
// Directed and randomized checks for serial_subtractor16 against a reference subtraction.
module tb_serial_subtractor16;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        bin;
  logic [15:0] diff;
  logic        bout;
  logic        ovf;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  serial_subtractor16 dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .diff  (diff),
    .bout  (bout),
    .ovf   (ovf),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  // Drive a request for one cycle; returns at the sampling point of RUN cycle 1.
  task automatic start_op(input logic [15:0] av, input logic [15:0] bv, input logic bi);
    @(negedge clk);
    start = 1'b1; a = av; b = bv; bin = bi;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Sample each cycle until done; diff must hold at 'held' while running.
  task automatic wait_done(input logic [15:0] held, output int nbusy, output bit seen);
    nbusy = 0;
    seen  = 1'b0;
    for (int i = 0; i < 40; i++) begin
      checks++;
      if (busy && done) begin
        errors++;
        $display("FAIL busy_done_overlap: busy=%0b done=%0b required not both", busy, done);
      end
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (busy) nbusy++;
      checks++;
      if (diff !== held) begin
        errors++;
        $display("FAIL diff_hold: got %h required %h", diff, held);
      end
      @(negedge clk);
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL done_timeout: no done within 40 cycles");
    end
  endtask

  task automatic expect_result(input string name, input logic [15:0] ed, input logic eb,
                               input logic eo);
    checks++;
    if ({diff, bout, ovf} !== {ed, eb, eo}) begin
      errors++;
      $display("FAIL %s: got diff=%h bout=%0b ovf=%0b required diff=%h bout=%0b ovf=%0b",
               name, diff, bout, ovf, ed, eb, eo);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({diff, bout, ovf, busy, done} !== 21'd0) begin
      errors++;
      $display("FAIL reset_state: got diff=%h bout=%0b ovf=%0b busy=%0b done=%0b required all 0",
               diff, bout, ovf, busy, done);
    end
  endtask

  task automatic test_basic();
    int nb; bit seen;
    start_op(16'h0005, 16'h0003, 1'b0);
    wait_done(16'h0000, nb, seen);
    checks++;
    if (nb != 16) begin
      errors++;
      $display("FAIL busy_cycles: got %0d required 16", nb);
    end
    expect_result("sub_5_3", 16'h0002, 1'b0, 1'b0);
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL done_pulse_width: got done=%0b busy=%0b required 0 0", done, busy);
    end
  endtask

  task automatic test_borrow();
    int nb; bit seen;
    start_op(16'h0003, 16'h0005, 1'b0);
    wait_done(16'h0002, nb, seen);
    expect_result("sub_3_5", 16'hFFFE, 1'b1, 1'b0);
    start_op(16'h0000, 16'h0000, 1'b1);
    wait_done(16'hFFFE, nb, seen);
    expect_result("sub_0_0_bin", 16'hFFFF, 1'b1, 1'b0);
    start_op(16'h1357, 16'h1357, 1'b0);
    wait_done(16'hFFFF, nb, seen);
    expect_result("sub_equal", 16'h0000, 1'b0, 1'b0);
  endtask

  task automatic test_overflow();
    int nb; bit seen;
    start_op(16'h8000, 16'h0001, 1'b0);
    wait_done(16'h0000, nb, seen);
    expect_result("ovf_neg", 16'h7FFF, 1'b0, 1'b1);
    start_op(16'h7FFF, 16'hFFFF, 1'b0);
    wait_done(16'h7FFF, nb, seen);
    expect_result("ovf_pos", 16'h8000, 1'b1, 1'b1);
  endtask

  task automatic test_back_to_back();
    int nb; bit seen;
    start_op(16'h1234, 16'h0234, 1'b0);
    repeat (4) @(negedge clk);
    start = 1'b1; a = 16'hFFFF;
    @(negedge clk);
    start = 1'b0;
    wait_done(16'h8000, nb, seen);
    expect_result("start_ignored", 16'h1000, 1'b0, 1'b0);
    start = 1'b1; a = 16'h0010; b = 16'h0001; bin = 1'b0;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || diff !== 16'h1000) begin
      errors++;
      $display("FAIL b2b_accept: got busy=%0b diff=%h required busy=1 diff=1000", busy, diff);
    end
    wait_done(16'h1000, nb, seen);
    expect_result("b2b_result", 16'h000F, 1'b0, 1'b0);
  endtask

  task automatic test_mid_reset();
    int nb; bit seen; bit pulsed;
    start_op(16'hAAAA, 16'h5555, 1'b0);
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({diff, bout, ovf, busy, done} !== 21'd0) begin
      errors++;
      $display("FAIL mid_reset: got diff=%h bout=%0b ovf=%0b busy=%0b done=%0b required all 0",
               diff, bout, ovf, busy, done);
    end
    pulsed = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (done || busy) pulsed = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (pulsed) begin
      errors++;
      $display("FAIL abort_quiet: got activity after reset required none");
    end
    start_op(16'hAAAA, 16'h5555, 1'b0);
    wait_done(16'h0000, nb, seen);
    expect_result("after_reset", 16'h5555, 1'b0, 1'b1);
  endtask

  task automatic test_random();
    int nb; bit seen;
    logic [15:0] av, bv, held;
    logic        bi;
    logic [16:0] ref_full;
    logic        ref_ovf;
    held = diff;
    for (int n = 0; n < 1000; n++) begin
      av = 16'($urandom);
      bv = 16'($urandom);
      bi = 1'($urandom_range(0, 1));
      ref_full = {1'b0, av} - {1'b0, bv} - {16'd0, bi};
      ref_ovf  = (av[15] != bv[15]) && (ref_full[15] != av[15]);
      start_op(av, bv, bi);
      wait_done(held, nb, seen);
      checks++;
      if ({diff, bout, ovf} !== {ref_full[15:0], ref_full[16], ref_ovf}) begin
        errors++;
        $display("FAIL random_%0d: a=%h b=%h bin=%0b got %h/%0b/%0b required %h/%0b/%0b",
                 n, av, bv, bi, diff, bout, ovf, ref_full[15:0], ref_full[16], ref_ovf);
      end
      held = ref_full[15:0];
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_borrow();
    test_overflow();
    test_back_to_back();
    test_mid_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
